// File: rtl/vga_pwm_pkg.sv
`default_nettype none
// ============================================================================
// vga_pwm_pkg: dither mode encoding, idle phase and Bayer index helper.
// Revision: 1.0
// ============================================================================
package vga_pwm_pkg;

  typedef enum logic [1:0] {
    PWM_MODE_LINE     = 2'd0,
    PWM_MODE_BAYER    = 2'd1,
    PWM_MODE_TEMPORAL = 2'd2,
    PWM_MODE_RSVD     = 2'd3
  } pwm_mode_e;

  // Phase 3 never compares below a 2-bit LSB value, so it means "no boost".
  localparam logic [1:0] PWM_PHASE_IDLE = 2'd3;

  function automatic logic [1:0] bayer_idx(input logic x0, input logic y0);
    return {x0 ^ y0, y0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pwm_sync_edge.sv
`default_nettype none
// ============================================================================
// vga_pwm_sync_edge: registers one sync input and flags its rising/falling edge.
// Revision: 1.0
// ============================================================================
module vga_pwm_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_i,
  output logic rise_o,
  output logic fall_o
);

  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= sync_i;
    end
  end

  assign rise_o = sync_i & ~sync_q;
  assign fall_o = ~sync_i & sync_q;

endmodule
`default_nettype wire

// File: rtl/vga_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// vga_pwm_ctrl: dither phase scheduler with frame-aligned configuration shadows.
// Revision: 1.0
// ============================================================================
module vga_pwm_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_pix,
  input  logic       de,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       csync,
  input  logic       cfg_pwm_en,
  input  logic       cfg_csync_en,
  input  logic [1:0] cfg_mode,
  output logic       pwm_en,
  output logic [1:0] phase,
  output logic [1:0] frame,
  output logic       cfg_pending
);
  import vga_pwm_pkg::*;

  logic      pwm_en_q, pwm_en_d;
  logic      csync_en_q, csync_en_d;
  pwm_mode_e mode_q, mode_d;
  logic      x0_q, x0_d;
  logic      y0_q, y0_d;
  logic [1:0] frame_q, frame_d;
  logic [1:0] phase_q, phase_d;

  logic       w_ssync;
  logic       w_line_start;
  logic       w_frame_start;
  logic       w_unused_line_rise;
  logic       w_unused_frame_fall;
  logic       w_en_eff;
  logic [1:0] w_bayer;

  assign w_ssync = csync_en_q ? csync : hsync;

  vga_pwm_sync_edge u_line_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .sync_i  (w_ssync),
    .rise_o  (w_unused_line_rise),
    .fall_o  (w_line_start)
  );

  vga_pwm_sync_edge u_frame_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .sync_i  (vsync),
    .rise_o  (w_frame_start),
    .fall_o  (w_unused_frame_fall)
  );

  // Dropping cfg_pwm_en must silence the datapath on the very next clk.
  assign w_en_eff = pwm_en_q & cfg_pwm_en;
  assign w_bayer  = bayer_idx(x0_q, y0_q);

  always_comb begin
    pwm_en_d   = pwm_en_q;
    csync_en_d = csync_en_q;
    mode_d     = mode_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    frame_d    = frame_q;
    phase_d    = PWM_PHASE_IDLE;

    if (w_frame_start) begin
      pwm_en_d   = cfg_pwm_en;
      csync_en_d = cfg_csync_en;
      mode_d     = pwm_mode_e'(cfg_mode);
      frame_d    = frame_q + 2'd1;
    end
    if (!cfg_pwm_en) begin
      pwm_en_d = 1'b0;
    end

    if (w_line_start) begin
      x0_d = 1'b0;
    end else if (ce_pix && de) begin
      x0_d = ~x0_q;
    end

    if (w_frame_start) begin
      y0_d = 1'b0;
    end else if (w_line_start) begin
      y0_d = ~y0_q;
    end

    if (w_en_eff && !w_ssync) begin
      case (mode_q)
        PWM_MODE_BAYER:    phase_d = de ? w_bayer : PWM_PHASE_IDLE;
        PWM_MODE_TEMPORAL: phase_d = de ? (w_bayer + frame_q) : PWM_PHASE_IDLE;
        default:           phase_d = phase_q + 2'd1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_en_q   <= 1'b0;
      csync_en_q <= 1'b0;
      mode_q     <= PWM_MODE_LINE;
      x0_q       <= 1'b0;
      y0_q       <= 1'b0;
      frame_q    <= 2'd0;
      phase_q    <= PWM_PHASE_IDLE;
    end else begin
      pwm_en_q   <= pwm_en_d;
      csync_en_q <= csync_en_d;
      mode_q     <= mode_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      frame_q    <= frame_d;
      phase_q    <= phase_d;
    end
  end

  assign pwm_en      = pwm_en_q;
  assign phase       = phase_q;
  assign frame       = frame_q;
  assign cfg_pending = (cfg_pwm_en ^ pwm_en_q) | (cfg_csync_en ^ csync_en_q) |
                       (|(cfg_mode ^ mode_q));

endmodule
`default_nettype wire

// File: tb/tb_vga_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// tb_vga_pwm_ctrl: directed stimulus with a queued-expectation scoreboard.
// Revision: 1.0
// ============================================================================
module tb_vga_pwm_ctrl;

  logic       clk;
  logic       reset_n;
  logic       ce_pix, de, hsync, vsync, csync;
  logic       cfg_pwm_en, cfg_csync_en;
  logic [1:0] cfg_mode;
  logic       pwm_en;
  logic [1:0] phase;
  logic [1:0] frame;
  logic       cfg_pending;

  vga_pwm_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ce_pix       (ce_pix),
    .de           (de),
    .hsync        (hsync),
    .vsync        (vsync),
    .csync        (csync),
    .cfg_pwm_en   (cfg_pwm_en),
    .cfg_csync_en (cfg_csync_en),
    .cfg_mode     (cfg_mode),
    .pwm_en       (pwm_en),
    .phase        (phase),
    .frame        (frame),
    .cfg_pending  (cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int F_PH = 0;
  localparam int F_EN = 1;
  localparam int F_FR = 2;
  localparam int F_PD = 3;

  typedef struct {
    int         tgt;   // posedge index to check after, -1 = on reset assertion
    string      nm;
    int         f;
    logic [1:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;
  exp_t e_pos;
  exp_t e_rst;

  task automatic check_one(input exp_t e);
    logic [1:0] act;
    case (e.f)
      F_PH:    act = phase;
      F_EN:    act = {1'b0, pwm_en};
      F_FR:    act = frame;
      default: act = {1'b0, cfg_pending};
    endcase
    total++;
    if (act === e.v) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", e.nm, act, e.v, cyc);
  endtask

  // Monitor: after each clock edge, compare every expectation due at it.
  always begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    while (q.size() > 0 && q[0].tgt != -1 && q[0].tgt <= cyc) begin
      e_pos = q.pop_front();
      check_one(e_pos);
    end
  end

  always begin
    @(negedge reset_n);
    #1;
    while (q.size() > 0 && q[0].tgt == -1) begin
      e_rst = q.pop_front();
      check_one(e_rst);
    end
  end

  task automatic exp(input string nm, input int f, input logic [1:0] v);
    q.push_back('{cyc + 1, nm, f, v});
  endtask

  task automatic exp_rst(input string nm, input int f, input logic [1:0] v);
    q.push_back('{-1, nm, f, v});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic vs_pulse(input logic [1:0] fexp, input logic pexp);
    hsync = 1'b1; csync = 1'b1;
    exp("vs_sync_phase", F_PH, 2'd3);
    tick();
    hsync = 1'b0; csync = 1'b0; vsync = 1'b1;
    exp("vs_frame", F_FR, fexp);
    exp("vs_pwm_en", F_EN, {1'b0, pexp});
    tick();
    vsync = 1'b0;
    tick();
  endtask

  task automatic line4(input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] c, input logic [1:0] d);
    logic [1:0] ev [4];
    ev = '{a, b, c, d};
    de = 1'b1; ce_pix = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp("pixel_phase", F_PH, ev[i]);
      tick();
    end
    de = 1'b0; ce_pix = 1'b0;
    exp("blank_phase", F_PH, 2'd3);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0] line_seq [6];
    line_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    reset_n = 1'b0;
    ce_pix = 1'b0; de = 1'b0; hsync = 1'b0; vsync = 1'b0; csync = 1'b0;
    cfg_pwm_en = 1'b0; cfg_csync_en = 1'b0; cfg_mode = 2'd0;
    repeat (3) tick();

    // Reset release and enable staging.
    reset_n = 1'b1;
    exp("rst_phase", F_PH, 2'd3);
    exp("rst_pwm_en", F_EN, 2'd0);
    exp("rst_frame", F_FR, 2'd0);
    exp("rst_pending", F_PD, 2'd0);
    tick();
    cfg_pwm_en = 1'b1;
    exp("en_pending", F_PD, 2'd1);
    exp("en_wait_pwm", F_EN, 2'd0);
    exp("en_wait_phase", F_PH, 2'd3);
    tick();
    exp("en_wait_pwm2", F_EN, 2'd0);
    tick();
    vs_pulse(2'd1, 1'b1);

    // LINE mode.
    hsync = 1'b1;
    exp("line_sync_phase", F_PH, 2'd3);
    exp("line_pending", F_PD, 2'd0);
    tick();
    exp("line_sync_phase2", F_PH, 2'd3);
    tick();
    hsync = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp("line_count", F_PH, line_seq[i]);
      tick();
    end

    // Stage BAYER mid-frame; LINE keeps running until frame start.
    cfg_mode = 2'd1;
    exp("stage_pending", F_PD, 2'd1);
    exp("stage_phase_hold", F_PH, 2'd2);
    tick();
    exp("stage_phase_hold2", F_PH, 2'd3);
    tick();
    vs_pulse(2'd2, 1'b1);
    exp("bayer_pending", F_PD, 2'd0);
    line4(2'd0, 2'd2, 2'd0, 2'd2);
    hsync = 1'b1;
    exp("bayer_hs_phase", F_PH, 2'd3);
    tick();
    hsync = 1'b0;
    exp("bayer_hs_fall", F_PH, 2'd3);
    tick();
    line4(2'd3, 2'd1, 2'd3, 2'd1);

    // TEMPORAL mode across frames, including the 3 -> 0 wrap.
    cfg_mode = 2'd2;
    exp("temp_pending", F_PD, 2'd1);
    tick();
    vs_pulse(2'd3, 1'b1);
    line4(2'd3, 2'd1, 2'd3, 2'd1);
    vs_pulse(2'd0, 1'b1);
    line4(2'd0, 2'd2, 2'd0, 2'd2);
    vs_pulse(2'd1, 1'b1);
    vs_pulse(2'd2, 1'b1);
    line4(2'd2, 2'd0, 2'd2, 2'd0);
    vs_pulse(2'd3, 1'b1);
    vs_pulse(2'd0, 1'b1);
    line4(2'd0, 2'd2, 2'd0, 2'd2);

    // Composite sync source: hsync is ignored, csync drives line start.
    cfg_csync_en = 1'b1; cfg_mode = 2'd1;
    exp("csync_pending", F_PD, 2'd1);
    tick();
    vs_pulse(2'd1, 1'b1);
    hsync = 1'b1;
    exp("csync_applied", F_PD, 2'd0);
    line4(2'd0, 2'd2, 2'd0, 2'd2);
    hsync = 1'b0;
    exp("csync_hs_fall", F_PH, 2'd3);
    tick();
    line4(2'd0, 2'd2, 2'd0, 2'd2);
    csync = 1'b1;
    exp("csync_high", F_PH, 2'd3);
    tick();
    csync = 1'b0;
    exp("csync_fall", F_PH, 2'd3);
    tick();
    line4(2'd3, 2'd1, 2'd3, 2'd1);

    cfg_mode = 2'd0;
    exp("csline_pending", F_PD, 2'd1);
    tick();
    vs_pulse(2'd2, 1'b1);
    csync = 1'b1;
    exp("csline_sync", F_PH, 2'd3);
    tick();
    csync = 1'b0; hsync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp("csline_count", F_PH, line_seq[i]);
      tick();
    end
    hsync = 1'b0;

    // Immediate disable, and disable coinciding with frame start.
    cfg_pwm_en = 1'b0;
    exp("dis_pwm_en", F_EN, 2'd0);
    exp("dis_phase", F_PH, 2'd3);
    exp("dis_pending", F_PD, 2'd0);
    tick();
    exp("dis_phase2", F_PH, 2'd3);
    tick();
    cfg_pwm_en = 1'b1;
    exp("reen_pending", F_PD, 2'd1);
    tick();
    hsync = 1'b1; csync = 1'b1;
    tick();
    hsync = 1'b0; csync = 1'b0; vsync = 1'b1; cfg_pwm_en = 1'b0;
    exp("fs_dis_pwm_en", F_EN, 2'd0);
    exp("fs_dis_frame", F_FR, 2'd3);
    tick();
    vsync = 1'b0;
    exp("fs_dis_pwm_en2", F_EN, 2'd0);
    exp("fs_dis_phase", F_PH, 2'd3);
    tick();
    cfg_pwm_en = 1'b1;
    vs_pulse(2'd0, 1'b1);
    exp("reen_count1", F_PH, 2'd1);
    tick();
    exp("reen_count2", F_PH, 2'd2);
    tick();
    vs_pulse(2'd1, 1'b1);
    tick();

    // Asynchronous reset mid-line.
    #2;
    exp_rst("arst_phase", F_PH, 2'd3);
    exp_rst("arst_pwm_en", F_EN, 2'd0);
    exp_rst("arst_frame", F_FR, 2'd0);
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    exp("post_rst_pwm_en", F_EN, 2'd0);
    exp("post_rst_pending", F_PD, 2'd1);
    exp("post_rst_phase", F_PH, 2'd3);
    tick();
    exp("post_rst_pwm_en2", F_EN, 2'd0);
    tick();
    vs_pulse(2'd1, 1'b1);
    exp("post_rst_applied", F_PD, 2'd0);
    tick();

    repeat (3) tick();
    if (q.size() != 0) begin
      total++;
      $display("FAIL queue_drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_pwm_ctrl.md
# vga_pwm_ctrl

Phase scheduler and configuration controller for the 18-bit VGA PWM dither datapath. It tracks pixel, line and frame position from the video timing signals and produces the 2-bit dither phase that the datapath compares against the two truncated LSBs of each colour channel. It also double-buffers the dither configuration so that mode changes take effect only at frame boundaries. It sits between the scaler/video timing output and the PWM datapath, in the `clk` domain of the VGA output.

## Interface
Parameters:
- none

Ports (clock and reset first):
- `clk`  in  1  video clock; the same clock as the PWM datapath.
- `reset_n`  in  1  asynchronous active-low reset.
- `ce_pix`  in  1  pixel clock enable.
- `de`  in  1  display enable; active pixels when high.
- `hsync`  in  1  horizontal sync, active high.
- `vsync`  in  1  vertical sync, active high.
- `csync`  in  1  composite sync, active high.
- `cfg_pwm_en`  in  1  requested PWM enable.
- `cfg_csync_en`  in  1  requested line-sync source: 1 selects `csync`, 0 selects `hsync`.
- `cfg_mode`  in  2  requested dither mode (see Operation).
- `pwm_en`  out  1  applied enable, to the datapath.
- `phase`  out  2  dither phase, to the datapath.
- `frame`  out  2  frame counter, modulo 4.
- `cfg_pending`  out  1  requested configuration differs from the applied configuration.

## Operation
- **Selected sync.** `ssync = csync_en_s ? csync : hsync`, where `csync_en_s` is the shadow (applied) copy of `cfg_csync_en`.
- **Edge detection.** `ssync` and `vsync` are registered once. From these:
  - line start = `ssync` falling edge;
  - frame start = `vsync` rising edge.
- **Shadow configuration.**
  - `pwm_en_s`, `csync_en_s` and `mode_s` load from the `cfg_*` inputs on the frame start cycle.
  - `pwm_en_s` is also forced to 0 immediately when `cfg_pwm_en` = 0. Disable is immediate; enable waits for the next frame.
  - `cfg_pending` = OR of the bitwise mismatches between the `cfg_*` inputs and the shadow registers.
- **Position counters.**
  - `x0` toggles on `ce_pix & de`. It clears at line start.
  - `y0` toggles at line start. It clears at frame start; frame start wins over a simultaneous line start.
  - `frame` increments at frame start and wraps 3 to 0.
- **Bayer index.** `b = {x0 ^ y0, y0}`, which gives the 2x2 ordered matrix 0, 2 / 3, 1.
- **Phase selection.** Next `phase` is chosen in priority order:
  - `pwm_en_s` = 0 → 3;
  - `ssync` = 1 → 3. Phase 3 is the "no boost" value, because `phase` < lsb is never true;
  - `mode_s` = 0 (LINE) → `phase + 1` every `clk`. This wraps, and restarts from 3 after each sync;
  - `mode_s` = 1 (BAYER) → `de ? b : 3`;
  - `mode_s` = 2 (TEMPORAL) → `de ? (b + frame) mod 4 : 3`;
  - `mode_s` = 3 (reserved) → behaves as LINE.
- **Arithmetic.** All sums are 2-bit and wrap naturally; no saturation is applied.

## Timing
- **Reset values.** `phase` = 3, `pwm_en` = 0, `frame` = 0, `cfg_pending` = 0 (combinational output), `x0` = `y0` = 0, shadows = 0 (mode LINE, hsync source).
- **Latency.** 1 `clk` from `de`/`ssync`/`ce_pix` to `phase`. Line and frame start use the registered edge, so the counter effects appear 1 `clk` after the detected edge.
- **Config apply.** The shadow registers update on the same `clk` edge that registers the frame start. The resulting `phase` is visible 1 `clk` later.
- **Sync source change.** A change of `csync_en_s` at frame start may create a spurious line-start edge. This is accepted, because it happens inside vertical sync.
- **Simultaneous events.**
  - Frame start and line start together → `y0` = 0, `x0` = 0.
  - Frame start together with `cfg_pwm_en` falling → `pwm_en_s` = 0.
- **Reset mid-line.** Asynchronous return to the reset values. Resuming from reset waits for the next frame start before `pwm_en` rises.

## Structure
- **Package `vga_pwm_pkg`.**
  - Mode constants: `PWM_MODE_LINE` = 0, `PWM_MODE_BAYER` = 1, `PWM_MODE_TEMPORAL` = 2, `PWM_MODE_RSVD` = 3.
  - Constant `PWM_PHASE_IDLE` = 2'd3.
- **Sub-module `vga_pwm_sync_edge`.** Registers one sync input and outputs the rise and fall pulses. It is instantiated twice: once for `ssync` and once for `vsync`.

## Test plan
- **Reset and idle.** Assert `reset_n` = 0 mid-line → `phase` = 3, `pwm_en` = 0, `frame` = 0 asynchronously. Release it, then drive `cfg_pwm_en` = 1 → `pwm_en` = 1 only after the first `vsync` rise.
- **LINE mode.** With `hsync` low for 6 clks after a sync pulse → `phase` = 0, 1, 2, 3, 0, 1. While `hsync` is high → `phase` = 3.
- **BAYER mode, 2 lines × 4 pixels, `de` = 1.**
  - Line 0 → `phase` 0, 2, 0, 2.
  - Line 1 → 3, 1, 3, 1.
  - `de` = 0 → 3.
- **TEMPORAL mode.** At `frame` = 2, the line 0 sequence is 2, 0, 2, 0. After 4 `vsync` rises, `frame` wraps to 0 and the sequence returns to 0, 2.
- **Configuration staging.**
  - Change `cfg_mode` mid-frame → `cfg_pending` = 1 and `phase` is unchanged. After the next `vsync` rise, the new mode applies and `cfg_pending` = 0.
  - `cfg_pwm_en` 1 → 0 mid-line → `pwm_en` = 0 and `phase` = 3 on the next `clk`.
- **Sync source.** With `cfg_csync_en` = 1, toggling `hsync` alone causes no line start and no `y0` change. A `csync` pulse restarts `y0`/`x0` and the LINE counter.
